// File: rtl/muldiv_unit_pkg.sv
// rv32ima_pkg: shared operation and FSM state types for the multiply/divide unit.
package rv32ima_pkg;
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake between the execute stage (master) and the unit (slave).
interface muldiv_unit_if #(parameter int WIDTH = 32);
    import rv32ima_pkg::*;
    logic             in_valid;
    logic             in_ready;
    muldiv_op_t       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;
    modport master (output in_valid, op, in1, in2, flush, out_ready,
                    input  in_ready, out_valid, out, busy);
    modport slave  (input  in_valid, op, in1, in2, flush, out_ready,
                    output in_ready, out_valid, out, busy);
endinterface

// File: rtl/muldiv_unit_div_step.sv
// muldiv_div_step: one restoring-division step; shifts in a dividend bit and conditionally subtracts.
module muldiv_div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] sh, diff;
    assign sh = {rem, in_bit};
    assign diff = sh - {1'b0, divisor};
    // sh < 2*divisor always, so the top bit of diff is a clean borrow flag
    assign q_bit = !diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready handshake and flush.
// MULDIV_FAST_MUL_EN: when defined, multiplies finish in one cycle; only divides iterate.
module muldiv_unit
    import rv32ima_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          CLK,
    input logic          nRST,
    muldiv_unit_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    state;
    muldiv_op_t       op_q;
    logic [WIDTH-1:0] a, b, res;
    logic [W2-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, out_valid_q;

    logic             is_div, s1, s2, n1, n2, div_zero, ovf, direct;
    logic [WIDTH-1:0] abs1, abs2, special, direct_res;

    assign is_div = bus.op[2];
    assign s1 = bus.op inside {MULH, MULHSU, DIV, REM};
    assign s2 = bus.op inside {MULH, DIV, REM};
    assign n1 = s1 && bus.in1[WIDTH-1];
    assign n2 = s2 && bus.in2[WIDTH-1];
    assign abs1 = n1 ? -bus.in1 : bus.in1;
    assign abs2 = n2 ? -bus.in2 : bus.in2;
    assign div_zero = is_div && bus.in2 == '0;
    assign ovf = (bus.op inside {DIV, REM}) && bus.in1 == {1'b1, {(WIDTH-1){1'b0}}} && &bus.in2;
    // op[1] separates remainders from quotients among the divide encodings
    assign special = div_zero ? (bus.op[1] ? bus.in1 : '1) : (bus.op[1] ? '0 : bus.in1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [W2-1:0] x1, x2, full;
    assign x1 = {{WIDTH{n1}}, bus.in1};
    assign x2 = {{WIDTH{n2}}, bus.in2};
    assign full = x1 * x2;
    assign direct = div_zero || ovf || !is_div;
    assign direct_res = is_div ? special : (bus.op == MUL ? full[WIDTH-1:0] : full[W2-1:WIDTH]);
`else
    assign direct = div_zero || ovf;
    assign direct_res = special;
`endif

    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next, div_next, acc_next, prod;
    logic [WIDTH-1:0] rem_next, quo, rem, fixed;
    logic             q_bit;

    // multiply: acc = {partial high, remaining multiplier bits}, shifted right each step
    assign mul_sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    muldiv_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (acc[W2-1:WIDTH]),
        .in_bit   (acc[WIDTH-1]),
        .divisor  (b),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );
    assign div_next = {rem_next, acc[WIDTH-2:0], q_bit};
    assign acc_next = op_q[2] ? div_next : mul_next;

    assign prod = neg_q ? -acc_next : acc_next;
    assign quo = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    assign rem = neg_r ? -acc_next[W2-1:WIDTH] : acc_next[W2-1:WIDTH];
    assign fixed = op_q[2] ? (op_q[1] ? rem : quo)
                           : (op_q == MUL ? prod[WIDTH-1:0] : prod[W2-1:WIDTH]);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            op_q        <= MUL;
            a           <= '0;
            b           <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            res         <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q        <= bus.op;
                    a           <= abs1;
                    b           <= abs2;
                    neg_q       <= n1 ^ n2;
                    neg_r       <= n1;
                    acc         <= {{WIDTH{1'b0}}, is_div ? abs1 : abs2};
                    cnt         <= CW'(WIDTH - 1);
                    res         <= direct_res;
                    state       <= direct ? DONE : CALC;
                    out_valid_q <= direct;
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        res         <= fixed;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = state == IDLE;
    assign bus.busy = state != IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.out = res;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at WIDTH=32 plus a WIDTH=16 divide regression.
module tb_muldiv_unit;
    import rv32ima_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit_if #(.WIDTH(16)) bus16 ();

    muldiv_unit #(.WIDTH(32)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
    muldiv_unit #(.WIDTH(16)) dut16 (.CLK(CLK), .nRST(nRST), .bus(bus16));

    // Stimulus only: starts and ends at a falling edge; cyc is the cycle out_valid was seen (1 = right after acceptance)
    task automatic issue(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                         input bit drain, output logic [31:0] r, output int cyc);
        int w = 0;
        bus.op = o;
        bus.in1 = x;
        bus.in2 = y;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 100) begin
            @(negedge CLK);
            w++;
        end
        @(negedge CLK);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        r = bus.out;
        if (drain) begin
            bus.out_ready = 1'b1;
            @(negedge CLK);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks += 4;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        if (bus.out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", bus.out); end
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_divide();
        logic [31:0] r;
        int c;
        issue(DIVU, 32'd100, 32'd7, 1'b1, r, c);
        checks += 2;
        if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", r, 32'd14); end
        if (c !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", c); end
        issue(REMU, 32'd100, 32'd7, 1'b1, r, c);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", r, 32'd2); end
        issue(DIV, -32'sd100, 32'd7, 1'b1, r, c);
        checks++;
        if (r !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_m100_7 got %h want fffffff2", r); end
        issue(REM, -32'sd100, 32'd7, 1'b1, r, c);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem_m100_7 got %h want fffffffe", r); end
    endtask

    task automatic test_special();
        logic [31:0] r;
        int c;
        issue(DIV, 32'd5, 32'd0, 1'b1, r, c);
        checks += 2;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero got %h want ffffffff", r); end
        if (c !== 1) begin errors++; $display("FAIL div_by_zero_latency got %0d want 1", c); end
        issue(REMU, 32'd5, 32'd0, 1'b1, r, c);
        checks++;
        if (r !== 32'd5) begin errors++; $display("FAIL remu_by_zero got %h want 5", r); end
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, c);
        checks += 2;
        if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h want 80000000", r); end
        if (c !== 1) begin errors++; $display("FAIL div_overflow_latency got %0d want 1", c); end
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, c);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL rem_overflow got %h want 0", r); end
    endtask

    task automatic test_multiply();
        logic [31:0] r;
        int c;
        issue(MULH, 32'h8000_0000, 32'h8000_0000, 1'b1, r, c);
        checks++;
        if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_min_min got %h want 40000000", r); end
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, c);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max got %h want fffffffe", r); end
        issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, c);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_m1 got %h want ffffffff", r); end
        issue(MUL, -32'sd3, 32'd7, 1'b1, r, c);
        checks++;
        if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_m3_7 got %h want ffffffeb", r); end
    endtask

    task automatic test_hold();
        logic [31:0] r;
        int c;
        issue(DIVU, 32'd100, 32'd7, 1'b0, r, c);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.out !== 32'd14 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d out=%h valid=%b in_ready=%b want 0000000e/1/0", i, bus.out, bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        bus.out_ready = 1'b0;
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int c;
        bus.op = DIVU;
        bus.in1 = 32'd1000;
        bus.in2 = 32'd10;
        bus.in_valid = 1'b1;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b want 1", bus.busy); end
        bus.flush = 1'b1;
        @(negedge CLK);
        bus.flush = 1'b0;
        checks += 3;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        issue(DIVU, 32'd1000, 32'd10, 1'b1, r, c);
        checks += 2;
        if (r !== 32'd100) begin errors++; $display("FAIL flush_followup got %h want %h", r, 32'd100); end
        if (c !== 33) begin errors++; $display("FAIL flush_followup_latency got %0d want 33", c); end
    endtask

    task automatic test_async_reset();
        bus.op = DIVU;
        bus.in1 = 32'd77;
        bus.in2 = 32'd3;
        bus.in_valid = 1'b1;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        checks += 2;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", bus.busy); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b want 0", bus.out_valid); end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_width16();
        int c = 1;
        bus16.op = DIVU;
        bus16.in1 = 16'hFFFF;
        bus16.in2 = 16'd3;
        bus16.in_valid = 1'b1;
        @(negedge CLK);
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && c < 100) begin
            @(negedge CLK);
            c++;
        end
        checks += 2;
        if (bus16.out !== 16'h5555) begin errors++; $display("FAIL w16_divu got %h want 5555", bus16.out); end
        if (c !== 17) begin errors++; $display("FAIL w16_latency got %0d want 17", c); end
        bus16.out_ready = 1'b1;
        @(negedge CLK);
        bus16.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int c;
        issue(DIV, 32'd7, 32'hFFFF_FFFD, 1'b1, r, c);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_div_7_m3 got %h want fffffffe", r); end
        issue(REM, 32'd7, 32'hFFFF_FFFD, 1'b1, r, c);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL b2b_rem_7_m3 got %h want 1", r); end
        issue(MULHU, 32'h0001_0000, 32'h0003_0000, 1'b1, r, c);
        checks++;
        if (r !== 32'd3) begin errors++; $display("FAIL b2b_mulhu got %h want 3", r); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op = MUL;
        bus.in1 = '0;
        bus.in2 = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.op = MUL;
        bus16.in1 = '0;
        bus16.in2 = '0;
        bus16.flush = 1'b0;
        bus16.out_ready = 1'b0;
        test_reset();
        test_divide();
        test_special();
        test_multiply();
        test_hold();
        test_flush();
        test_async_reset();
        test_width16();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the RV32IMA core. It implements the full M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a parametrised data width, behind a valid/ready handshake on both sides. It sits beside the single-cycle ALU in the execute stage and is the home for division and remainder. The execute stage stalls on `busy` and can abort an operation with `flush` on a redirect.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be even and ≥ 8.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  clock, all state on rising edge
- `nRST`  in  1  asynchronous active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  unit can accept a request; high iff state is IDLE
- `op`  in  3  `muldiv_op_t` operation code
- `in1`, `in2`  in  WIDTH  rs1 / rs2 operands
- `flush`  in  1  synchronous abort of any in-flight or held operation
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out`  out  WIDTH  result
- `busy`  out  1  state is not IDLE

## Operation
- FSM states are IDLE, CALC and DONE.
- **IDLE → CALC:** on `in_valid && in_ready && !flush`. Latch `op`, the absolute values of the operands per signedness, and the result sign. Load the iteration counter with WIDTH−1.
- **IDLE → DONE (special cases, no CALC):**
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give `in1`.
  - Signed overflow (`in1` = −2^(WIDTH−1), `in2` = −1): DIV gives `in1`; REM gives 0.
- **CALC:** one bit per cycle.
  - Multiply is shift-add into a 2·WIDTH product.
  - Divide is restoring: shift the remainder, subtract the divisor, set the quotient bit when the remainder stays non-negative.
  - Counter reaches 0 → DONE.
- **Sign fix-up in the CALC→DONE transition:**
  - Negate the quotient or product if the result sign is set.
  - The remainder takes the sign of the dividend.
  - MULHSU: only `in1` is signed.
- **Result select:** MUL gives the low half of the product. MULH/MULHSU/MULHU give the high half.
- **DONE:** `out_valid`=1 and `out` is held stable until `out_ready`. Then DONE → IDLE.
- **Flush:** `flush` in any state → IDLE next cycle and the result is discarded. Flush has priority over `in_valid` and `out_ready`.
- **Reset:** `nRST` low forces IDLE immediately, mid-operation included. Reset values:
  - `out_valid`=0, `out`=0, `busy`=0
  - `in_ready`=1
  - all internal registers 0
- Undefined `op` encodings are accepted and produce 0 after one cycle (IDLE → DONE).

## Timing
- Handshake at cycle 0 (acceptance edge). Then:
  - Iterative op: `out_valid` rises after cycle WIDTH, i.e. visible on cycle WIDTH+1. For WIDTH=32 that is 33 cycles request-to-result.
  - Special case or single-cycle multiply: `out_valid` visible on cycle 1.
- Result transfer happens on the edge where `out_valid && out_ready`. `in_ready` rises the next cycle; there is no same-cycle back-to-back issue.
- `in_ready` and `busy` are decoded from registered state only; there is no combinational path from inputs.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: MUL* ops compute the full 2·WIDTH product in a single cycle (IDLE → DONE), and only divides iterate.
  - Undefined: multiplies use the shift-add CALC path (WIDTH cycles), for area-constrained synthesis.
- Results are bit-identical either way.

## Structure
- `muldiv_op_t` (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7) and the `muldiv_state_t` enum go in `rv32ima_pkg`.
- Width constants are derived from `WIDTH` locally.
- One sub-module, `muldiv_div_step`: combinational single restoring-divide step (remainder, divisor → next remainder, quotient bit), instantiated once inside the CALC datapath.

## Test plan
- DIVU 100/7 → out=14 at cycle 33; REMU 100/7 → 2. DIV −100/7 → −14; REM −100/7 → −2.
- DIV 5/0 → 0xFFFFFFFF at cycle 1; REMU 5/0 → 5. DIV 0x80000000/−1 → 0x80000000; REM → 0.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF. MUL −3×7 → 0xFFFFFFEB.
- Hold `out_ready`=0 for 5 cycles after DONE → `out` stable, `in_ready`=0. Release → `in_ready`=1 next cycle.
- `flush` at cycle 10 of a DIVU → IDLE at cycle 11, no `out_valid`. New request at cycle 11 completes correctly.
- `nRST` low mid-CALC → `busy`=0 and `out_valid`=0 asynchronously. WIDTH=16 regression: DIVU 0xFFFF/3 → 0x5555 at cycle 17.
